mario_sprite_fetch: RTL and testbench

MARIO_SPRITE_FETCH -- requirements
Module: mario_sprite_fetch

---
 rtl/mario_pkg.sv | 22 ++
 rtl/mario_anim_fsm.sv | 74 +++++++
 rtl/mario_sprite_fetch.sv | 94 +++++++++
 tb/tb_mario_sprite_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario sprite fetch block: animation states,
// ROM frame indices and the transparent colour key.
package mario_pkg;

  typedef enum logic [1:0] {
    ST_STAND = 2'd0,
    ST_WALK  = 2'd1,
    ST_JUMP  = 2'd2
  } anim_state_t;

  localparam logic [2:0]  FRAME_STAND     = 3'd0;
  localparam logic [2:0]  FRAME_WALK0     = 3'd1;
  localparam logic [2:0]  FRAME_JUMP      = 3'd4;
  localparam int          FRAME_WORDS     = 256;
  localparam logic [23:0] TRANSPARENT_KEY = 24'hFF00FF;

  // Walk cycle is three frames long: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_walk_phase(input logic [1:0] phase);
    return (phase == 2'd2) ? 2'd0 : phase + 2'd1;
  endfunction

endpackage

// File: rtl/mario_anim_fsm.sv
// Animation state machine: picks stand/walk/jump once per video frame and
// steps the walk cycle every ANIM_DIV frames. Frame index is held between ticks.
module mario_anim_fsm
  import mario_pkg::*;
#(
  parameter int ANIM_DIV = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_i,
  input  logic        moving_i,
  input  logic        airborne_i,
  output logic [2:0]  frame_o,
  output anim_state_t state_o
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(ANIM_DIV - 1);

  anim_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       phase_q, phase_d;
  logic [2:0]       frame_q, frame_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STAND;
      div_q   <= '0;
      phase_q <= '0;
      frame_q <= FRAME_STAND;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    frame_d = frame_q;
    if (frame_tick_i) begin
      if (airborne_i) begin
        state_d = ST_JUMP;
        div_d   = '0;
        phase_d = '0;
        frame_d = FRAME_JUMP;
      end else if (moving_i) begin
        state_d = ST_WALK;
        if (state_q != ST_WALK) begin
          div_d   = '0;
          phase_d = '0;
        end else if (div_q == DIV_MAX) begin
          div_d   = '0;
          phase_d = next_walk_phase(phase_q);
        end else begin
          div_d   = div_q + 1'b1;
        end
        frame_d = FRAME_WALK0 + {1'b0, phase_d};
      end else begin
        state_d = ST_STAND;
        div_d   = '0;
        phase_d = '0;
        frame_d = FRAME_STAND;
      end
    end
  end

  assign frame_o = frame_q;
  assign state_o = state_q;

endmodule

// File: rtl/mario_sprite_fetch.sv
// Raster-driven sprite fetch: hit test against the sprite box, ROM address
// generation with horizontal mirroring, and colour-key masking of the ROM word.
module mario_sprite_fetch
  import mario_pkg::*;
#(
  parameter int          SPRITE_W    = 16,
  parameter int          ANIM_DIV    = 6,
  parameter logic [23:0] TRANSPARENT = TRANSPARENT_KEY
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  MarioX,
  input  logic [9:0]  MarioY,
  input  logic        moving,
  input  logic        airborne,
  input  logic        facing_left,
  output logic [10:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic [23:0] pixel_rgb,
  output logic        pixel_on,
  output logic [1:0]  dbg_anim_state
);

  logic [2:0]  frame;
  anim_state_t anim_state;

  mario_anim_fsm #(.ANIM_DIV(ANIM_DIV)) u_fsm (
    .clk          (Clk),
    .rst          (Reset),
    .frame_tick_i (frame_tick),
    .moving_i     (moving),
    .airborne_i   (airborne),
    .frame_o      (frame),
    .state_o      (anim_state)
  );

  assign dbg_anim_state = anim_state;

  logic        facing_q;
  logic [10:0] rom_addr_q, rom_addr_d;
  logic        hit1_q, hit2_q;
  logic [23:0] pixel_rgb_q, pixel_rgb_d;
  logic        pixel_on_q, pixel_on_d;

  // Widened to 11 bits so a sprite near the right/bottom edge cannot wrap.
  logic [10:0] dx, dy, mx, my, off_x, off_y;
  logic        hit;
  logic [3:0]  col, row;

  always_comb begin
    dx    = {1'b0, DrawX};
    dy    = {1'b0, DrawY};
    mx    = {1'b0, MarioX};
    my    = {1'b0, MarioY};
    off_x = dx - mx;
    off_y = dy - my;
    hit   = (dx >= mx) && (dx < mx + 11'(SPRITE_W)) &&
            (dy >= my) && (dy < my + 11'(SPRITE_W));
    row   = off_y[3:0];
    col   = facing_q ? (4'hF - off_x[3:0]) : off_x[3:0];
    rom_addr_d = hit ? {frame, row, col} : 11'd0;
  end

  always_comb begin
    pixel_on_d  = hit2_q && (rom_data != TRANSPARENT);
    pixel_rgb_d = pixel_on_d ? rom_data : 24'd0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      facing_q    <= 1'b0;
      rom_addr_q  <= '0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      pixel_rgb_q <= '0;
      pixel_on_q  <= 1'b0;
    end else begin
      if (frame_tick) facing_q <= facing_left;
      rom_addr_q  <= rom_addr_d;
      hit1_q      <= hit;
      hit2_q      <= hit1_q;
      pixel_rgb_q <= pixel_rgb_d;
      pixel_on_q  <= pixel_on_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pixel_rgb = pixel_rgb_q;
  assign pixel_on  = pixel_on_q;

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Directed bench for mario_sprite_fetch with a behavioural synchronous ROM.
module tb_mario_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic [9:0]  DrawX, DrawY, MarioX, MarioY;
  logic        moving, airborne, facing_left;
  logic [10:0] rom_addr;
  logic [23:0] rom_data;
  logic [23:0] pixel_rgb;
  logic        pixel_on;
  logic [1:0]  dbg_anim_state;

  int n_checks = 0;
  int n_errors = 0;
  int rom_force = 0;
  int prev_frame = 0;

  always #5 Clk = ~Clk;

  mario_sprite_fetch dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_tick     (frame_tick),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .MarioX         (MarioX),
    .MarioY         (MarioY),
    .moving         (moving),
    .airborne       (airborne),
    .facing_left    (facing_left),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .pixel_rgb      (pixel_rgb),
    .pixel_on       (pixel_on),
    .dbg_anim_state (dbg_anim_state)
  );

  function automatic logic [23:0] rom_fn(input logic [10:0] a);
    return {13'h155, a};
  endfunction

  // One-cycle synchronous ROM, with overrides for colour-key tests.
  always @(posedge Clk) begin
    if (rom_force == 1)      rom_data <= 24'hFF00FF;
    else if (rom_force == 2) rom_data <= 24'h00FF00;
    else                     rom_data <= rom_fn(rom_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Pulse frame_tick; the address on the tick edge still uses the old frame,
  // the following edge shows the new one.
  task automatic tick_check(input string tag, input int exp_frame);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    chk({tag, "_old"}, 32'(rom_addr[10:8]), 32'(prev_frame));
    cyc(1);
    chk({tag, "_new"}, 32'(rom_addr[10:8]), 32'(exp_frame));
    prev_frame = exp_frame;
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0;
    DrawX = '0; DrawY = '0; MarioX = '0; MarioY = '0;
    moving = 1'b0; airborne = 1'b0; facing_left = 1'b0;
    rom_data = '0;
    cyc(2);
    chk("rst_addr",  32'(rom_addr),  32'd0);
    chk("rst_rgb",   32'(pixel_rgb), 32'd0);
    chk("rst_on",    32'(pixel_on),  32'd0);
    chk("rst_state", 32'(dbg_anim_state), 32'd0);
    Reset = 1'b0;

    // Standing sprite, top-left pixel.
    MarioX = 10'd100; MarioY = 10'd200; DrawX = 10'd100; DrawY = 10'd200;
    cyc(1);
    chk("stand_addr", 32'(rom_addr), 32'd0);
    cyc(2);
    chk("stand_rgb", 32'(pixel_rgb), 32'(rom_fn(11'd0)));
    chk("stand_on",  32'(pixel_on),  32'd1);

    // Walk cycle: 1 for ticks 1-6, 2 for 7-12, 3 for 13-18, back to 1 on 19.
    moving = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      tick_check($sformatf("walk%0d", i), 1 + ((i - 1) / 6) % 3);
    end
    chk("walk_state", 32'(dbg_anim_state), 32'd1);
    airborne = 1'b1;
    tick_check("jump", 4);
    chk("jump_addr",  32'(rom_addr), 32'd1024);
    chk("jump_state", 32'(dbg_anim_state), 32'd2);

    // Mirrored standing sprite.
    airborne = 1'b0; moving = 1'b0; facing_left = 1'b1;
    tick_check("stand_l", 0);
    DrawX = 10'd102; DrawY = 10'd203;
    cyc(1);
    chk("mirror_addr", 32'(rom_addr), 32'd61);
    facing_left = 1'b0;
    cyc(1);
    chk("mirror_hold", 32'(rom_addr), 32'd61);
    tick_check("stand_r", 0);
    chk("unmirror_addr", 32'(rom_addr), 32'd50);

    // Box edges.
    DrawX = 10'd115; DrawY = 10'd200;
    cyc(1);
    chk("edge_in", 32'(rom_addr), 32'd15);
    DrawX = 10'd116;
    cyc(1);
    chk("edge_out_x", 32'(rom_addr), 32'd0);
    DrawX = 10'd100; DrawY = 10'd216;
    cyc(1);
    chk("edge_out_y", 32'(rom_addr), 32'd0);
    DrawX = 10'd99; DrawY = 10'd200;
    cyc(1);
    chk("edge_left", 32'(rom_addr), 32'd0);

    // Right screen edge: no wrap at 1023.
    MarioX = 10'd1015; DrawX = 10'd1023; DrawY = 10'd200;
    cyc(1);
    chk("wide_hit_addr", 32'(rom_addr), 32'd8);
    cyc(2);
    chk("wide_hit_rgb", 32'(pixel_rgb), 32'(rom_fn(11'd8)));
    chk("wide_hit_on",  32'(pixel_on),  32'd1);
    DrawX = 10'd5;
    cyc(1);
    chk("wrap_miss_addr", 32'(rom_addr), 32'd0);
    cyc(2);
    chk("wrap_miss_on",  32'(pixel_on),  32'd0);
    chk("wrap_miss_rgb", 32'(pixel_rgb), 32'd0);

    // Colour key on a hit pixel.
    DrawX = 10'd1023;
    rom_force = 1;
    cyc(4);
    chk("key_on",  32'(pixel_on),  32'd0);
    chk("key_rgb", 32'(pixel_rgb), 32'd0);
    rom_force = 2;
    cyc(3);
    chk("green_on",  32'(pixel_on),  32'd1);
    chk("green_rgb", 32'(pixel_rgb), 32'h00FF00);
    rom_force = 0;

    // Reset mid-walk at phase 2, then restart the cycle.
    MarioX = 10'd100; DrawX = 10'd100; DrawY = 10'd200;
    moving = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick_check($sformatf("rwalk%0d", i), 1 + ((i - 1) / 6) % 3);
    end
    cyc(2);
    chk("pre_rst_on", 32'(pixel_on), 32'd1);
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("async_addr", 32'(rom_addr),  32'd0);
    chk("async_rgb",  32'(pixel_rgb), 32'd0);
    chk("async_on",   32'(pixel_on),  32'd0);
    chk("async_state", 32'(dbg_anim_state), 32'd0);
    cyc(1);
    Reset = 1'b0;
    prev_frame = 0;
    tick_check("restart", 1);
    chk("restart_addr", 32'(rom_addr), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
